de4_qsys_nios2_qsys_div_cell: RTL and testbench
===============================================

DE4_QSYS_NIOS2_QSYS_DIV_CELL -- requirements
Module: de4_qsys_nios2_qsys_div_cell

Interface
REQ-001 SHALL have port clk, input, 1, single clock; all logic rising-edge.
REQ-002 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port E_div_start, input, 1, start request (sampled in IDLE only).
REQ-004 SHALL have port E_div_abort, input, 1, pipeline flush; cancels operation in progress.
REQ-005 SHALL have port E_ctrl_div_signed, input, 1, 1 = signed two's-complement, 0 = unsigned; sampled with start.
REQ-006 SHALL have port E_src1_div_cell, input, 32, dividend; sampled with start.
REQ-007 SHALL have port E_src2_div_cell, input, 32, divisor; sampled with start.
REQ-008 SHALL have port A_div_quotient, output, 32, quotient.
REQ-009 SHALL have port A_div_remainder, output, 32, remainder.
REQ-010 SHALL have port A_div_busy, output, 1, high in RUN and FIXUP.
REQ-011 SHALL have port A_div_done, output, 1, one-cycle pulse, results valid.
REQ-012 SHALL have port A_div_by_zero, output, 1, divisor was zero; valid with done, held with results.

Function
REQ-013 SHALL implement FSM states IDLE, RUN, FIXUP, DONE.
REQ-014 IDLE: start=1 and abort=0 -> latch operands/mode, take absolute values if signed, clear counter, go RUN.
REQ-015 RUN: one radix-2 restoring step per cycle, 32 cycles (counter 0..31), then FIXUP.
REQ-016 FIXUP: negate quotient if signed and operand signs differ; negate remainder if signed and dividend negative; go DONE.
REQ-017 DONE: load outputs, assert A_div_done for exactly one cycle, return to IDLE.
REQ-018 Latency SHALL be fixed: start sampled at edge N -> A_div_done high in cycle N+34.
REQ-019 Outputs SHALL hold last results until next DONE; not cleared by start or abort.
REQ-020 start while busy SHALL be ignored, no queuing.
REQ-021 abort in RUN/FIXUP SHALL force IDLE next cycle; no done pulse; outputs unchanged.
REQ-022 abort and start in same IDLE cycle: abort wins, start dropped.
REQ-023 divisor = 0: full latency kept; quotient = 0xFFFFFFFF, remainder = dividend unmodified, A_div_by_zero = 1.
REQ-024 Signed 0x80000000 / 0xFFFFFFFF SHALL yield quotient 0x80000000, remainder 0, by_zero 0 (wraps, no trap).
REQ-025 Signed division SHALL truncate toward zero; remainder takes dividend sign.
REQ-026 Internal partial remainder SHALL be 33 bits; magnitude of 0x80000000 handled as unsigned 2^31.

Reset
REQ-027 reset_n low SHALL asynchronously force IDLE, counter 0, all outputs 0 (busy, done, by_zero, quotient, remainder).
REQ-028 Reset mid-operation SHALL discard the operation; no done after release.
REQ-029 First start SHALL be accepted in the first cycle after reset_n deasserts.

Structure
REQ-030 Shared package SHALL hold: state enum type, DIV_WIDTH = 32, DIV_ITER = 32, DIV0_QUOTIENT = 32'hFFFFFFFF.
REQ-031 One sub-module SHALL be used: de4_qsys_nios2_qsys_div_step, combinational single restoring step (33-bit subtract, quotient bit, next remainder).
REQ-032 No vendor megafunctions; target 120-400 lines RTL.

Verification
REQ-033 Unsigned 100/7 -> quotient 14, remainder 2, done exactly 34 cycles after start, busy high 33 cycles.
REQ-034 Signed -7/2 (0xFFFFFFF9/0x2) -> quotient 0xFFFFFFFD, remainder 0xFFFFFFFF; unsigned same operands -> 0x7FFFFFFC, 1.
REQ-035 Signed 0x80000000/0xFFFFFFFF -> 0x80000000, 0; unsigned -> 0x00000000, 0x80000000.
REQ-036 5/0 -> quotient 0xFFFFFFFF, remainder 5, by_zero 1; next op 9/3 -> 3, 0, by_zero 0.
REQ-037 Start 50/5, second start at cycle 5 ignored, abort at cycle 10 -> busy low at cycle 11, no done; new start 50/5 -> 10, 0.
REQ-038 reset_n low at cycle 20 of RUN -> all outputs 0 same cycle; no done after release.

Source files
------------

// File: rtl/de4_qsys_nios2_qsys_div_cell_pkg.sv
// Shared types and constants for the iterative 32-bit divider cell.
// Holds the FSM state type, sizing constants and the magnitude helper.
package de4_qsys_nios2_qsys_div_cell_pkg;

    localparam int DIV_WIDTH = 32;
    localparam int DIV_ITER  = 32;
    localparam int CNT_W     = $clog2(DIV_ITER);

    localparam logic [DIV_WIDTH-1:0] DIV0_QUOTIENT = 32'hFFFFFFFF;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FIXUP,
        S_DONE
    } div_state_e;

    // 0x80000000 maps onto itself, which reads correctly as unsigned 2^31
    function automatic logic [DIV_WIDTH-1:0] abs_val(
        input logic [DIV_WIDTH-1:0] v,
        input logic                 en
    );
        return (en && v[DIV_WIDTH-1]) ? -v : v;
    endfunction

endpackage

// File: rtl/de4_qsys_nios2_qsys_div_cell_if.sv
// Request/result bundle between the execute stage and the divider cell.
// The master drives operands and control; the slave returns results.
interface de4_qsys_nios2_qsys_div_cell_if;
    import de4_qsys_nios2_qsys_div_cell_pkg::*;

    logic                 E_div_start;
    logic                 E_div_abort;
    logic                 E_ctrl_div_signed;
    logic [DIV_WIDTH-1:0] E_src1_div_cell;
    logic [DIV_WIDTH-1:0] E_src2_div_cell;
    logic [DIV_WIDTH-1:0] A_div_quotient;
    logic [DIV_WIDTH-1:0] A_div_remainder;
    logic                 A_div_busy;
    logic                 A_div_done;
    logic                 A_div_by_zero;

    modport master (
        output E_div_start, E_div_abort, E_ctrl_div_signed,
        output E_src1_div_cell, E_src2_div_cell,
        input  A_div_quotient, A_div_remainder,
        input  A_div_busy, A_div_done, A_div_by_zero
    );

    modport slave (
        input  E_div_start, E_div_abort, E_ctrl_div_signed,
        input  E_src1_div_cell, E_src2_div_cell,
        output A_div_quotient, A_div_remainder,
        output A_div_busy, A_div_done, A_div_by_zero
    );

endinterface

// File: rtl/de4_qsys_nios2_qsys_div_step.sv
// One radix-2 restoring division step, purely combinational.
// Shifts the next dividend bit in, trial-subtracts, keeps or restores.
module de4_qsys_nios2_qsys_div_step
    import de4_qsys_nios2_qsys_div_cell_pkg::*;
(
    input  logic [DIV_WIDTH:0]   rem_i,
    input  logic                 bit_i,
    input  logic [DIV_WIDTH-1:0] dvsr_i,
    output logic [DIV_WIDTH:0]   rem_o,
    output logic                 qbit_o
);

    logic [DIV_WIDTH+1:0] shl;
    logic [DIV_WIDTH+1:0] diff;

    // Extra top bit of diff acts as the borrow out of the trial subtract
    always_comb begin
        shl    = {rem_i, bit_i};
        diff   = shl - {2'b00, dvsr_i};
        qbit_o = ~diff[DIV_WIDTH+1];
        rem_o  = qbit_o ? diff[DIV_WIDTH:0] : shl[DIV_WIDTH:0];
    end

endmodule

// File: rtl/de4_qsys_nios2_qsys_div_cell.sv
// Multi-cycle signed/unsigned 32-bit divider with fixed 34-cycle latency.
// Magnitudes are divided by restoring steps, then signs are fixed up.
module de4_qsys_nios2_qsys_div_cell
    import de4_qsys_nios2_qsys_div_cell_pkg::*;
(
    input  logic                              clk,
    input  logic                              reset_n,
    de4_qsys_nios2_qsys_div_cell_if.slave     bus
);

    div_state_e           state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [DIV_WIDTH-1:0] q_q, q_d;
    logic [DIV_WIDTH:0]   r_q, r_d;
    logic [DIV_WIDTH-1:0] dvsr_q, dvsr_d;
    logic [DIV_WIDTH-1:0] dvnd_q, dvnd_d;
    logic                 negq_q, negq_d;
    logic                 negr_q, negr_d;
    logic                 zero_q, zero_d;
    logic [DIV_WIDTH-1:0] quot_q, quot_d;
    logic [DIV_WIDTH-1:0] rem_q, rem_d;
    logic                 by0_q, by0_d;
    logic                 done_q, done_d;
    logic                 busy;
    logic                 accept;

    logic [DIV_WIDTH:0]   step_rem;
    logic                 step_qbit;

    assign accept = bus.E_div_start && !bus.E_div_abort;

    de4_qsys_nios2_qsys_div_step u_step (
        .rem_i  (r_q),
        .bit_i  (q_q[DIV_WIDTH-1]),
        .dvsr_i (dvsr_q),
        .rem_o  (step_rem),
        .qbit_o (step_qbit)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (accept) state_d = S_RUN;
            S_RUN: begin
                if (bus.E_div_abort) begin
                    state_d = S_IDLE;
                end else if (cnt_q == CNT_W'(DIV_ITER - 1)) begin
                    state_d = S_FIXUP;
                end
            end
            S_FIXUP: state_d = bus.E_div_abort ? S_IDLE : S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q == S_RUN) || (state_q == S_FIXUP);
    end

    always_comb begin
        cnt_d  = cnt_q;
        q_d    = q_q;
        r_d    = r_q;
        dvsr_d = dvsr_q;
        dvnd_d = dvnd_q;
        negq_d = negq_q;
        negr_d = negr_q;
        zero_d = zero_q;
        quot_d = quot_q;
        rem_d  = rem_q;
        by0_d  = by0_q;
        done_d = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    negq_d = bus.E_ctrl_div_signed &&
                             (bus.E_src1_div_cell[DIV_WIDTH-1] ^
                              bus.E_src2_div_cell[DIV_WIDTH-1]);
                    negr_d = bus.E_ctrl_div_signed &&
                             bus.E_src1_div_cell[DIV_WIDTH-1];
                    dvnd_d = bus.E_src1_div_cell;
                    dvsr_d = abs_val(bus.E_src2_div_cell,
                                     bus.E_ctrl_div_signed);
                    q_d    = abs_val(bus.E_src1_div_cell,
                                     bus.E_ctrl_div_signed);
                    r_d    = '0;
                    cnt_d  = '0;
                    zero_d = (bus.E_src2_div_cell == '0);
                end
            end
            S_RUN: begin
                q_d   = {q_q[DIV_WIDTH-2:0], step_qbit};
                r_d   = step_rem;
                cnt_d = cnt_q + CNT_W'(1);
            end
            S_FIXUP: begin
                if (negq_q) q_d = -q_q;
                if (negr_q) r_d = {1'b0, -r_q[DIV_WIDTH-1:0]};
            end
            S_DONE: begin
                // Divide-by-zero reports the untouched original dividend
                quot_d = zero_q ? DIV0_QUOTIENT : q_q;
                rem_d  = zero_q ? dvnd_q : r_q[DIV_WIDTH-1:0];
                by0_d  = zero_q;
                done_d = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q  <= '0;
            q_q    <= '0;
            r_q    <= '0;
            dvsr_q <= '0;
            dvnd_q <= '0;
            negq_q <= 1'b0;
            negr_q <= 1'b0;
            zero_q <= 1'b0;
            quot_q <= '0;
            rem_q  <= '0;
            by0_q  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            q_q    <= q_d;
            r_q    <= r_d;
            dvsr_q <= dvsr_d;
            dvnd_q <= dvnd_d;
            negq_q <= negq_d;
            negr_q <= negr_d;
            zero_q <= zero_d;
            quot_q <= quot_d;
            rem_q  <= rem_d;
            by0_q  <= by0_d;
            done_q <= done_d;
        end
    end

    assign bus.A_div_quotient  = quot_q;
    assign bus.A_div_remainder = rem_q;
    assign bus.A_div_busy      = busy;
    assign bus.A_div_done      = done_q;
    assign bus.A_div_by_zero   = by0_q;

endmodule

// File: tb/tb_de4_qsys_nios2_qsys_div_cell.sv
// Bench for the divider cell: arithmetic reference model with a
// per-cycle compare, plus directed operations with literal results.
module tb_de4_qsys_nios2_qsys_div_cell;

    logic clk = 1'b0;
    logic reset_n = 1'b1;

    always #5 clk = ~clk;

    de4_qsys_nios2_qsys_div_cell_if bus ();

    de4_qsys_nios2_qsys_div_cell dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_div(input logic [31:0] a, input logic [31:0] b,
                             input logic s, output logic [31:0] q,
                             output logic [31:0] r, output logic z);
        longint sa, sb, qq, rr;
        if (b == 32'd0) begin
            q = 32'hFFFFFFFF;
            r = a;
            z = 1'b1;
        end else begin
            if (s) begin
                sa = longint'($signed(a));
                sb = longint'($signed(b));
            end else begin
                sa = longint'({32'd0, a});
                sb = longint'({32'd0, b});
            end
            qq = sa / sb;
            rr = sa % sb;
            q  = qq[31:0];
            r  = rr[31:0];
            z  = 1'b0;
        end
    endtask

    // Reference: one operation in flight, result due 34 edges after accept
    int          edge_n = 0;
    int          m_acc = 0;
    bit          m_pend = 0;
    logic        m_done = 1'b0;
    logic [31:0] m_q = '0, m_r = '0;
    logic        m_z = 1'b0;
    logic [31:0] p_q, p_r;
    logic        p_z;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_pend = 0;
            m_done = 1'b0;
            m_q    = '0;
            m_r    = '0;
            m_z    = 1'b0;
        end else begin
            edge_n++;
            m_done = 1'b0;
            if (m_pend) begin
                if (edge_n - m_acc == 34) begin
                    m_q    = p_q;
                    m_r    = p_r;
                    m_z    = p_z;
                    m_done = 1'b1;
                    m_pend = 0;
                end else if (bus.E_div_abort) begin
                    m_pend = 0;
                end
            end else if (bus.E_div_start && !bus.E_div_abort) begin
                m_pend = 1;
                m_acc  = edge_n;
                model_div(bus.E_src1_div_cell, bus.E_src2_div_cell,
                          bus.E_ctrl_div_signed, p_q, p_r, p_z);
            end
        end
    end

    always @(negedge clk) begin
        chk("cyc_busy", bus.A_div_busy,
            32'(m_pend && (edge_n - m_acc) <= 32));
        chk("cyc_done", bus.A_div_done, 32'(m_done));
        chk("cyc_quot", bus.A_div_quotient, m_q);
        chk("cyc_rem", bus.A_div_remainder, m_r);
        chk("cyc_by0", bus.A_div_by_zero, 32'(m_z));
    end

    task automatic start_op(input logic [31:0] a, input logic [31:0] b,
                            input logic s);
        @(negedge clk);
        bus.E_div_start       = 1'b1;
        bus.E_ctrl_div_signed = s;
        bus.E_src1_div_cell   = a;
        bus.E_src2_div_cell   = b;
        @(negedge clk);
        bus.E_div_start = 1'b0;
    endtask

    task automatic wait_done(input string name, input logic [31:0] eq,
                             input logic [31:0] er, input logic ez);
        int n = 0;
        int bc = bus.A_div_busy ? 1 : 0;
        while (!bus.A_div_done && n < 40) begin
            @(negedge clk);
            n++;
            if (bus.A_div_busy) bc++;
        end
        chk({name, "_done"}, bus.A_div_done, 32'd1);
        chk({name, "_lat"}, n, 34);
        chk({name, "_busycyc"}, bc, 33);
        chk({name, "_q"}, bus.A_div_quotient, eq);
        chk({name, "_r"}, bus.A_div_remainder, er);
        chk({name, "_z"}, bus.A_div_by_zero, 32'(ez));
    endtask

    task automatic do_op(input string name, input logic [31:0] a,
                         input logic [31:0] b, input logic s,
                         input logic [31:0] eq, input logic [31:0] er,
                         input logic ez);
        start_op(a, b, s);
        wait_done(name, eq, er, ez);
    endtask

    task automatic no_done(input string name, input int cyc);
        int d = 0;
        repeat (cyc) begin
            @(negedge clk);
            if (bus.A_div_done) d++;
        end
        chk(name, d, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.E_div_start       = 1'b0;
        bus.E_div_abort       = 1'b0;
        bus.E_ctrl_div_signed = 1'b0;
        bus.E_src1_div_cell   = '0;
        bus.E_src2_div_cell   = '0;
        #1 reset_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_quot", bus.A_div_quotient, 32'd0);
        chk("rst_busy", bus.A_div_busy, 32'd0);
        #2 reset_n = 1'b1;

        do_op("u100_7", 32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0);
        do_op("s-7_2", 32'hFFFFFFF9, 32'd2, 1'b1,
              32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0);
        do_op("u-7_2", 32'hFFFFFFF9, 32'd2, 1'b0,
              32'h7FFFFFFC, 32'd1, 1'b0);
        do_op("s_min_m1", 32'h80000000, 32'hFFFFFFFF, 1'b1,
              32'h80000000, 32'd0, 1'b0);
        do_op("u_min_m1", 32'h80000000, 32'hFFFFFFFF, 1'b0,
              32'd0, 32'h80000000, 1'b0);
        do_op("div0", 32'd5, 32'd0, 1'b0, 32'hFFFFFFFF, 32'd5, 1'b1);
        do_op("u9_3", 32'd9, 32'd3, 1'b0, 32'd3, 32'd0, 1'b0);
        do_op("s7_m2", 32'd7, 32'hFFFFFFFE, 1'b1,
              32'hFFFFFFFD, 32'd1, 1'b0);
        do_op("s_min_2", 32'h80000000, 32'd2, 1'b1,
              32'hC0000000, 32'd0, 1'b0);
        do_op("s_div0_neg", 32'hFFFFFFF0, 32'd0, 1'b1,
              32'hFFFFFFFF, 32'hFFFFFFF0, 1'b1);

        // Ignored restart while busy, then abort mid-run
        start_op(32'd50, 32'd5, 1'b0);
        repeat (4) @(negedge clk);
        bus.E_div_start     = 1'b1;
        bus.E_src1_div_cell = 32'd99;
        bus.E_src2_div_cell = 32'd2;
        @(negedge clk);
        bus.E_div_start = 1'b0;
        chk("restart_busy", bus.A_div_busy, 32'd1);
        repeat (4) @(negedge clk);
        bus.E_div_abort = 1'b1;
        @(negedge clk);
        bus.E_div_abort = 1'b0;
        chk("abort_busy", bus.A_div_busy, 32'd0);
        no_done("abort_nodone", 40);
        chk("abort_hold_q", bus.A_div_quotient, 32'hFFFFFFFF);
        chk("abort_hold_r", bus.A_div_remainder, 32'hFFFFFFF0);
        do_op("u50_5", 32'd50, 32'd5, 1'b0, 32'd10, 32'd0, 1'b0);

        // Abort wins over a simultaneous start in idle
        @(negedge clk);
        bus.E_div_start     = 1'b1;
        bus.E_div_abort     = 1'b1;
        bus.E_src1_div_cell = 32'd77;
        @(negedge clk);
        bus.E_div_start = 1'b0;
        bus.E_div_abort = 1'b0;
        chk("abst_busy", bus.A_div_busy, 32'd0);
        no_done("abst_nodone", 40);

        // Reset in the middle of a run
        start_op(32'd1000, 32'd3, 1'b0);
        repeat (20) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk("mrst_busy", bus.A_div_busy, 32'd0);
        chk("mrst_done", bus.A_div_done, 32'd0);
        chk("mrst_by0", bus.A_div_by_zero, 32'd0);
        chk("mrst_q", bus.A_div_quotient, 32'd0);
        chk("mrst_r", bus.A_div_remainder, 32'd0);
        repeat (2) @(negedge clk);
        #2 reset_n = 1'b1;
        no_done("mrst_nodone", 40);

        // Start accepted in the first cycle after reset release
        @(negedge clk);
        #2 reset_n = 1'b0;
        @(negedge clk);
        #2;
        reset_n               = 1'b1;
        bus.E_div_start       = 1'b1;
        bus.E_ctrl_div_signed = 1'b0;
        bus.E_src1_div_cell   = 32'd1000;
        bus.E_src2_div_cell   = 32'd10;
        @(negedge clk);
        bus.E_div_start = 1'b0;
        wait_done("first", 32'd100, 32'd0, 1'b0);
        repeat (3) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
